sorting: RTL and testbench

- Packet sorter with Avalon-ST sink and source.
- Buffers one packet of up to MAX_PKT_LEN words, sorts the words in ascending unsigned order, then streams the sorted packet out.
- Sits inline in a streaming datapath and holds one packet at a time (receive, sort, send).

---
 rtl/sorting_pkg.sv | 17 +
 rtl/sorting_ram.sv | 27 ++
 rtl/sorting.sv | 178 +++++++++++++++++
 tb/tb_sorting.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sorting_pkg.sv
// Shared types and width helpers for the packet sorter.
package sorting_pkg;

  typedef enum logic [1:0] {RECV, SORT, SEND} state_t;

  // RD issues a RAM read, CMP_WR consumes it, FLUSH stores the pass maximum
  typedef enum logic [1:0] {RD, CMP_WR, FLUSH} phase_t;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sorting_ram.sv
// Packet buffer: one write port, two registered read ports (read-old-data on collision).
module sorting_ram
  import sorting_pkg::*;
#(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned AW     = addr_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DWIDTH-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DWIDTH-1:0] rdata_b
);

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
  end

endmodule

// File: rtl/sorting.sv
// Store-and-forward packet sorter: receive one packet, bubble-sort it in place, stream it out.
module sorting
  import sorting_pkg::*;
#(
  parameter int unsigned DWIDTH      = 64,
  parameter int unsigned MAX_PKT_LEN = 128
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] snk_data_i,
  input  logic              snk_startofpacket_i,
  input  logic              snk_endofpacket_i,
  input  logic              snk_valid_i,
  output logic              snk_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i
);

  localparam int unsigned CW = cnt_width(MAX_PKT_LEN);
  localparam int unsigned AW = addr_width(MAX_PKT_LEN);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT_LEN);

  state_t            state;
  phase_t            phase;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     send_idx;
  logic [CW-1:0]     n_new;
  logic              started;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     pass_end;
  logic [DWIDTH-1:0] carry;

  logic              beat_in;
  logic              keep_word;
  logic              rd_gt;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DWIDTH-1:0] ram_wdata;
  logic [AW-1:0]     raddr_a;
  logic [AW-1:0]     raddr_b;
  logic [DWIDTH-1:0] rdata_a;
  logic [DWIDTH-1:0] rdata_b;

  sorting_ram #(
    .DWIDTH (DWIDTH),
    .DEPTH  (MAX_PKT_LEN),
    .AW     (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  // RAM port steering; a sort pass carries the running maximum and writes back the smaller word
  always_comb begin
    beat_in   = snk_valid_i & snk_ready_o;
    keep_word = snk_startofpacket_i | (started & (cnt < MAX_CNT));
    n_new     = snk_startofpacket_i ? CW'(1) : (keep_word ? cnt + CW'(1) : cnt);
    rd_gt     = rdata_a > carry;
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    raddr_a   = idx;
    raddr_b   = send_idx[AW-1:0];
    case (state)
      RECV: begin
        if (beat_in && keep_word) begin
          ram_we    = 1'b1;
          ram_waddr = snk_startofpacket_i ? '0 : cnt[AW-1:0];
          ram_wdata = snk_data_i;
        end
      end
      SORT: begin
        if (phase == CMP_WR && idx != '0) begin
          ram_we    = 1'b1;
          ram_waddr = idx - AW'(1);
          ram_wdata = rd_gt ? carry : rdata_a;
        end else if (phase == FLUSH) begin
          ram_we    = 1'b1;
          ram_waddr = pass_end;
          ram_wdata = carry;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state               <= RECV;
      phase               <= RD;
      cnt                 <= '0;
      send_idx            <= '0;
      started             <= 1'b0;
      idx                 <= '0;
      pass_end            <= '0;
      carry               <= '0;
      snk_ready_o         <= 1'b1;
      src_valid_o         <= 1'b0;
      src_startofpacket_o <= 1'b0;
      src_endofpacket_o   <= 1'b0;
      src_data_o          <= '0;
    end else begin
      case (state)
        RECV: begin
          if (beat_in) begin
            if (keep_word) begin
              cnt     <= n_new;
              started <= 1'b1;
            end
            if (snk_endofpacket_i && (snk_startofpacket_i || started)) begin
              snk_ready_o <= 1'b0;
              started     <= 1'b0;
              send_idx    <= '0;
              idx         <= '0;
              phase       <= RD;
              pass_end    <= AW'(n_new - CW'(1));
              state       <= (n_new == CW'(1)) ? SEND : SORT;
            end
          end
        end
        SORT: begin
          case (phase)
            RD: phase <= CMP_WR;
            CMP_WR: begin
              if (idx == '0 || rd_gt) carry <= rdata_a;
              if (idx == pass_end) begin
                phase <= FLUSH;
              end else begin
                idx   <= idx + AW'(1);
                phase <= RD;
              end
            end
            default: begin
              idx   <= '0;
              phase <= RD;
              if (pass_end == AW'(1)) state <= SEND;
              else                    pass_end <= pass_end - AW'(1);
            end
          endcase
        end
        SEND: begin
          // RD lets the registered read settle; CMP_WR presents and holds the beat
          if (phase == RD) begin
            phase <= CMP_WR;
          end else if (!src_valid_o) begin
            src_valid_o         <= 1'b1;
            src_data_o          <= rdata_b;
            src_startofpacket_o <= (send_idx == '0);
            src_endofpacket_o   <= (send_idx == cnt - CW'(1));
          end else if (src_ready_i) begin
            src_valid_o         <= 1'b0;
            src_startofpacket_o <= 1'b0;
            src_endofpacket_o   <= 1'b0;
            phase               <= RD;
            if (src_endofpacket_o) begin
              state       <= RECV;
              snk_ready_o <= 1'b1;
              cnt         <= '0;
            end else begin
              send_idx <= send_idx + CW'(1);
            end
          end
        end
        default: state <= RECV;
      endcase
    end
  end

endmodule

// File: tb/tb_sorting.sv
// Directed and randomized bench for the packet sorter against a queue-based sort model.
module tb_sorting;

  localparam int unsigned DW   = 64;
  // Reduced depth keeps the quadratic sort time short while exercising overflow
  localparam int unsigned MAXN = 16;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] snk_data;
  logic          snk_sop, snk_eop, snk_valid, snk_ready;
  logic [DW-1:0] src_data;
  logic          src_sop, src_eop, src_valid, src_ready;

  always #5 clk = ~clk;

  sorting #(.DWIDTH(DW), .MAX_PKT_LEN(MAXN)) dut (
    .clk_i               (clk),
    .srst_i              (srst),
    .snk_data_i          (snk_data),
    .snk_startofpacket_i (snk_sop),
    .snk_endofpacket_i   (snk_eop),
    .snk_valid_i         (snk_valid),
    .snk_ready_o         (snk_ready),
    .src_data_o          (src_data),
    .src_startofpacket_o (src_sop),
    .src_endofpacket_o   (src_eop),
    .src_valid_o         (src_valid),
    .src_ready_i         (src_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] b_data[$];
  logic          b_sop[$];
  logic          b_eop[$];
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_beats();
    b_data.delete(); b_sop.delete(); b_eop.delete();
  endtask

  task automatic add_beat(input logic [DW-1:0] d, input logic s, input logic e);
    b_data.push_back(d); b_sop.push_back(s); b_eop.push_back(e);
  endtask

  task automatic add_random_pkt(input int len);
    for (int i = 0; i < len; i++)
      add_beat({$urandom, $urandom}, i == 0, i == len - 1);
  endtask

  // Reference: collect the words of the packet closed by eop, keep at most MAXN, sort ascending
  task automatic build_expected();
    logic [DW-1:0] w[$];
    logic active = 1'b0;
    exp_q.delete();
    foreach (b_data[i]) begin
      if (b_sop[i]) begin
        w.delete();
        w.push_back(b_data[i]);
        active = 1'b1;
      end else if (active && w.size() < int'(MAXN)) begin
        w.push_back(b_data[i]);
      end
      if (b_eop[i] && active) begin
        exp_q  = w;
        active = 1'b0;
      end
    end
    exp_q.sort();
  endtask

  task automatic check_reset_outputs();
    check("rst_snk_ready", DW'(snk_ready), DW'(1));
    check("rst_src_valid", DW'(src_valid), DW'(0));
    check("rst_src_sop", DW'(src_sop), DW'(0));
    check("rst_src_eop", DW'(src_eop), DW'(0));
    check("rst_src_data", src_data, DW'(0));
  endtask

  task automatic send_beats(input int gap_pct);
    int i = 0;
    int cyc = 0;
    while (i < b_data.size() && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (snk_ready) check("recv_src_valid_low", DW'(src_valid), DW'(0));
      if (int'($urandom_range(99)) < gap_pct) begin
        snk_valid = 1'b0;
      end else begin
        snk_valid = 1'b1;
        snk_data  = b_data[i];
        snk_sop   = b_sop[i];
        snk_eop   = b_eop[i];
        if (snk_ready) i++;
      end
    end
    if (i < b_data.size()) check("send_timeout", DW'(i), DW'(b_data.size()));
    @(negedge clk);
    snk_valid = 1'b0;
    snk_sop   = 1'b0;
    snk_eop   = 1'b0;
  endtask

  task automatic recv_pkt(input int ready_pct);
    int n = exp_q.size();
    int k = 0;
    int c = 0;
    int budget = 2 * n * n + 60 * n + 40;
    logic stall = 1'b0;
    logic seen = 1'b0;
    logic [DW-1:0] pd = '0;
    logic ps = 1'b0;
    logic pe = 1'b0;
    while (k < n && c < budget) begin
      @(negedge clk);
      c++;
      if (stall) begin
        check("stall_valid", DW'(src_valid), DW'(1));
        check("stall_data", src_data, pd);
        check("stall_sop", DW'(src_sop), DW'(ps));
        check("stall_eop", DW'(src_eop), DW'(pe));
      end
      if (src_valid) check("send_snk_ready_low", DW'(snk_ready), DW'(0));
      if (src_valid && !seen) begin
        seen = 1'b1;
        check("sop_latency", DW'(c <= 2 * n * n + 2), DW'(1));
      end
      src_ready = (int'($urandom_range(99)) < ready_pct);
      stall = src_valid && !src_ready;
      pd = src_data;
      ps = src_sop;
      pe = src_eop;
      if (src_valid && src_ready) begin
        check("out_data", src_data, exp_q[k]);
        check("out_sop", DW'(src_sop), DW'(k == 0));
        check("out_eop", DW'(src_eop), DW'(k == n - 1));
        k++;
      end
    end
    check("recv_count", DW'(k), DW'(n));
    @(negedge clk);
    src_ready = 1'b0;
    check("ready_after_eop", DW'(snk_ready), DW'(1));
    check("valid_after_eop", DW'(src_valid), DW'(0));
  endtask

  task automatic run_pkt(input int gap_pct, input int ready_pct);
    build_expected();
    send_beats(gap_pct);
    recv_pkt(ready_pct);
  endtask

  initial begin
    srst = 1'b1; snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0;
    snk_valid = 1'b0; src_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    srst = 1'b0;

    // Single word with sop and eop together
    clear_beats(); add_beat(DW'(5), 1'b1, 1'b1);
    run_pkt(0, 100);

    // Already sorted 0..9
    clear_beats();
    for (int i = 0; i < 10; i++) add_beat(DW'(i), i == 0, i == 9);
    run_pkt(0, 100);

    // Reverse 10..1
    clear_beats();
    for (int i = 10; i >= 1; i--) add_beat(DW'(i), i == 10, i == 1);
    run_pkt(0, 100);

    // Beats before any sop are ignored, even one carrying eop
    clear_beats(); add_beat(DW'(7), 1'b0, 1'b0); add_beat(DW'(8), 1'b0, 1'b1);
    send_beats(0);
    repeat (4) begin
      @(negedge clk);
      check("orphan_snk_ready", DW'(snk_ready), DW'(1));
      check("orphan_src_valid", DW'(src_valid), DW'(0));
    end

    // Mid-packet sop restarts the packet
    clear_beats();
    add_beat(DW'(40), 1'b1, 1'b0); add_beat(DW'(30), 1'b0, 1'b0);
    add_beat(DW'(20), 1'b0, 1'b0); add_beat(DW'(10), 1'b0, 1'b0);
    add_beat(DW'(9), 1'b1, 1'b0); add_beat(DW'(3), 1'b0, 1'b0);
    add_beat(DW'(6), 1'b0, 1'b1);
    run_pkt(30, 100);

    // Overflow: words beyond the buffer depth are dropped, eop still closes the packet
    clear_beats(); add_random_pkt(int'(MAXN) + 4);
    run_pkt(20, 100);

    // Random data, random lengths, 50% input gaps
    for (int p = 0; p < 20; p++) begin
      clear_beats(); add_random_pkt(int'($urandom_range(MAXN, 1)));
      run_pkt(50, 100);
    end

    // Every length back-to-back, downstream always ready; includes duplicate words
    for (int len = 1; len <= int'(MAXN); len++) begin
      clear_beats();
      for (int i = 0; i < len; i++)
        add_beat(DW'($urandom_range(3)) << 62 | DW'($urandom_range(3)), i == 0, i == len - 1);
      run_pkt(0, 100);
    end

    // Random backpressure
    for (int p = 0; p < 10; p++) begin
      clear_beats(); add_random_pkt(int'($urandom_range(MAXN, 1)));
      run_pkt(25, 40);
    end

    // Reset during SORT aborts the packet
    clear_beats(); add_random_pkt(12);
    send_beats(0);
    repeat (5) @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    srst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    clear_beats(); add_random_pkt(9);
    run_pkt(10, 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
